// File: rtl/mandel_config_receiver.sv
// -----------------------------------------------------------------------------
// mandel_config_receiver
//
// Serial configuration front end for the Mandelbrot engine. Synchronises the
// three-wire sen/sdata/sclk interface from the host microcontroller, shifts in
// one frame of CFG_WIDTH bits (LSB first), checks the frame length, commits a
// good frame atomically to the configuration holding register and issues a
// single-cycle start pulse once the engine reports idle.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   sen_in       async frame enable, high for the whole frame
//   sdata_in     async serial data, LSB first
//   sclk_in      async serial clock, data sampled on its rising edge
//   engine_idle  engine can accept a new render
//   cfg_out      last committed configuration (changes only on commit)
//   cfg_valid    high once any frame has been committed
//   start        one-cycle render start pulse
//   frame_error  sticky: last frame had the wrong bit count
//   busy         state is not IDLE (registered with state)
// -----------------------------------------------------------------------------
module mandel_config_receiver #(
    parameter int CFG_WIDTH   = 52,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sen_in,
    input  logic                 sdata_in,
    input  logic                 sclk_in,
    input  logic                 engine_idle,
    output logic [CFG_WIDTH-1:0] cfg_out,
    output logic                 cfg_valid,
    output logic                 start,
    output logic                 frame_error,
    output logic                 busy
);

    // Counter must reach CFG_WIDTH+1 so that over-long frames stay distinguishable.
    localparam int                CNT_W    = $clog2(CFG_WIDTH + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CFG_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(CFG_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        PENDING
    } state_t;

    // Synchroniser chains: index 0 is the pin-side stage.
    logic [SYNC_STAGES-1:0] sen_sync_q,   sen_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q,  sclk_sync_d;
    logic [SYNC_STAGES-1:0] sdata_sync_q, sdata_sync_d;

    // Edge-history flops. sdata is only ever sampled, never edge-detected,
    // so it carries no history stage.
    logic sen_hist_q,  sen_hist_d;
    logic sclk_hist_q, sclk_hist_d;

    state_t                 state_q,       state_d;
    logic [CFG_WIDTH-1:0]   shift_reg_q,   shift_reg_d;
    logic [CNT_W-1:0]       bit_cnt_q,     bit_cnt_d;
    logic [CFG_WIDTH-1:0]   cfg_q,         cfg_d;
    logic                   cfg_valid_q,   cfg_valid_d;
    logic                   start_q,       start_d;
    logic                   frame_error_q, frame_error_d;
    logic                   busy_q,        busy_d;

    logic sen_s, sclk_s, sdata_s;
    logic sen_rise, sen_fall, sclk_rise;

    assign sen_s   = sen_sync_q[SYNC_STAGES-1];
    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign sdata_s = sdata_sync_q[SYNC_STAGES-1];

    assign sen_rise  =  sen_s  & ~sen_hist_q;
    assign sen_fall  = ~sen_s  &  sen_hist_q;
    assign sclk_rise =  sclk_s & ~sclk_hist_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        sen_sync_d    = {sen_sync_q[SYNC_STAGES-2:0],   sen_in};
        sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0],  sclk_in};
        sdata_sync_d  = {sdata_sync_q[SYNC_STAGES-2:0], sdata_in};
        sen_hist_d    = sen_s;
        sclk_hist_d   = sclk_s;
        state_d       = state_q;
        shift_reg_d   = shift_reg_q;
        bit_cnt_d     = bit_cnt_q;
        cfg_d         = cfg_q;
        cfg_valid_d   = cfg_valid_q;
        frame_error_d = frame_error_q;
        start_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sen_rise) begin
                    bit_cnt_d   = '0;
                    shift_reg_d = '0;
                    state_d     = RECV;
                end
            end

            RECV: begin
                // On a sen falling edge sen_s is already 0, so a coincident
                // sclk edge can never shift an extra bit.
                if (sen_fall) begin
                    if (bit_cnt_q == CNT_FULL) begin
                        cfg_d         = shift_reg_q;
                        cfg_valid_d   = 1'b1;
                        frame_error_d = 1'b0;
                        state_d       = PENDING;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = IDLE;
                    end
                end else if (sclk_rise && sen_s) begin
                    shift_reg_d = {sdata_s, shift_reg_q[CFG_WIDTH-1:1]};
                    if (bit_cnt_q != CNT_SAT) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            PENDING: begin
                // A new frame overrides the queued start; cfg_q keeps the
                // committed value until that frame itself commits.
                if (sen_rise) begin
                    bit_cnt_d   = '0;
                    shift_reg_d = '0;
                    state_d     = RECV;
                end else if (engine_idle) begin
                    start_d = 1'b1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // update together from pre-edge values.
        if (reset) begin
            // NOTE: every flop, synchronisers included, is reset so a frame
            // interrupted by reset is fully discarded.
            sen_sync_q    <= '0;
            sclk_sync_q   <= '0;
            sdata_sync_q  <= '0;
            sen_hist_q    <= 1'b0;
            sclk_hist_q   <= 1'b0;
            state_q       <= IDLE;
            shift_reg_q   <= '0;
            bit_cnt_q     <= '0;
            cfg_q         <= '0;
            cfg_valid_q   <= 1'b0;
            start_q       <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            sen_sync_q    <= sen_sync_d;
            sclk_sync_q   <= sclk_sync_d;
            sdata_sync_q  <= sdata_sync_d;
            sen_hist_q    <= sen_hist_d;
            sclk_hist_q   <= sclk_hist_d;
            state_q       <= state_d;
            shift_reg_q   <= shift_reg_d;
            bit_cnt_q     <= bit_cnt_d;
            cfg_q         <= cfg_d;
            cfg_valid_q   <= cfg_valid_d;
            start_q       <= start_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
        end
    end

    assign cfg_out     = cfg_q;
    assign cfg_valid   = cfg_valid_q;
    assign start       = start_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mandel_config_receiver.sv
// -----------------------------------------------------------------------------
// tb_mandel_config_receiver
//
// Directed bench for mandel_config_receiver: drives serial frames with an sclk
// period of 8 clk (50% duty), checks committed configuration, error flag,
// busy and start-pulse count/latency against hand-computed values.
// -----------------------------------------------------------------------------
module tb_mandel_config_receiver;

    localparam int CFG_WIDTH = 52;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 sen_in;
    logic                 sdata_in;
    logic                 sclk_in;
    logic                 engine_idle;
    logic [CFG_WIDTH-1:0] cfg_out;
    logic                 cfg_valid;
    logic                 start;
    logic                 frame_error;
    logic                 busy;

    int checks   = 0;
    int failures = 0;

    // Monitor state: cycle of last cfg_out change and of last start pulse.
    int                   cyc        = 0;
    int                   commit_cyc = 0;
    int                   start_cyc  = 0;
    int                   start_cnt  = 0;
    logic [CFG_WIDTH-1:0] prev_cfg   = '0;
    int                   starts_before;

    mandel_config_receiver #(
        .CFG_WIDTH  (CFG_WIDTH),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sen_in     (sen_in),
        .sdata_in   (sdata_in),
        .sclk_in    (sclk_in),
        .engine_idle(engine_idle),
        .cfg_out    (cfg_out),
        .cfg_valid  (cfg_valid),
        .start      (start),
        .frame_error(frame_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cfg_out !== prev_cfg) commit_cyc = cyc;
        prev_cfg = cfg_out;
        if (start === 1'b1) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns 1 clk-phase after the n-th rising edge.
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_begin();
        sen_in = 1'b1;
        wait_clks(4);
    endtask

    task automatic send_bits(input logic [63:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            sdata_in = d[i];
            sclk_in  = 1'b0;
            wait_clks(4);
            sclk_in  = 1'b1;
            wait_clks(4);
        end
    endtask

    task automatic frame_end();
        sclk_in = 1'b0;
        wait_clks(4);
        sen_in  = 1'b0;
        wait_clks(10);
    endtask

    initial begin
        reset       = 1'b1;
        sen_in      = 1'b0;
        sdata_in    = 1'b0;
        sclk_in     = 1'b0;
        engine_idle = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(1);

        // Reset state
        check("rst_cfg_out",     64'(cfg_out),     64'h0);
        check("rst_cfg_valid",   64'(cfg_valid),   64'h0);
        check("rst_start",       64'(start),       64'h0);
        check("rst_frame_error", 64'(frame_error), 64'h0);
        check("rst_busy",        64'(busy),        64'h0);

        // Short frame (51 bits) straight after reset
        starts_before = start_cnt;
        frame_begin();
        send_bits(64'h5555555555555, 51);
        frame_end();
        check("short_frame_error", 64'(frame_error), 64'h1);
        check("short_cfg_out",     64'(cfg_out),     64'h0);
        check("short_cfg_valid",   64'(cfg_valid),   64'h0);
        check("short_no_start",    64'(start_cnt - starts_before), 64'h0);
        check("short_busy",        64'(busy),        64'h0);

        // Valid frame, engine idle
        starts_before = start_cnt;
        frame_begin();
        send_bits(64'hFF123456789AB, 52);
        frame_end();
        check("ok1_cfg_out",       64'(cfg_out),     64'hFF123456789AB);
        check("ok1_cfg_valid",     64'(cfg_valid),   64'h1);
        check("ok1_frame_error",   64'(frame_error), 64'h0);
        check("ok1_start_count",   64'(start_cnt - starts_before), 64'h1);
        check("ok1_start_latency", 64'(start_cyc - commit_cyc),    64'h1);
        check("ok1_busy",          64'(busy),        64'h0);

        // Long frame (53 bits), then a good frame
        starts_before = start_cnt;
        frame_begin();
        send_bits(64'h1FFFFFFFFFFFFF, 53);
        frame_end();
        check("long_frame_error", 64'(frame_error), 64'h1);
        check("long_cfg_out",     64'(cfg_out),     64'hFF123456789AB);
        check("long_no_start",    64'(start_cnt - starts_before), 64'h0);
        frame_begin();
        send_bits(64'h0000000000001, 52);
        frame_end();
        check("after_long_frame_error", 64'(frame_error), 64'h0);
        check("after_long_cfg_out",     64'(cfg_out),     64'h1);
        check("after_long_start_count", 64'(start_cnt - starts_before), 64'h1);

        // Engine busy: start held off until engine_idle rises
        engine_idle   = 1'b0;
        starts_before = start_cnt;
        frame_begin();
        send_bits(64'h123456789ABCD, 52);
        frame_end();
        check("hold_busy",    64'(busy),    64'h1);
        check("hold_cfg_out", 64'(cfg_out), 64'h123456789ABCD);
        wait_clks(100);
        check("hold_no_start_100", 64'(start_cnt - starts_before), 64'h0);
        check("hold_busy_100",     64'(busy),  64'h1);
        engine_idle = 1'b1;
        wait_clks(1);
        check("release_start_hi", 64'(start), 64'h1);
        check("release_busy_lo",  64'(busy),  64'h0);
        wait_clks(1);
        check("release_start_lo",    64'(start), 64'h0);
        check("release_start_count", 64'(start_cnt - starts_before), 64'h1);

        // New frame while PENDING cancels the queued start
        engine_idle   = 1'b0;
        starts_before = start_cnt;
        frame_begin();
        send_bits(64'h0F0F0F0F0F0F0, 52);
        frame_end();
        check("pend_cfg_out", 64'(cfg_out), 64'h0F0F0F0F0F0F0);
        check("pend_busy",    64'(busy),    64'h1);
        frame_begin();
        engine_idle = 1'b1;
        send_bits(64'hABCDE12345678, 52);
        check("cancel_cfg_hold",  64'(cfg_out), 64'h0F0F0F0F0F0F0);
        check("cancel_no_start",  64'(start_cnt - starts_before), 64'h0);
        check("cancel_busy",      64'(busy),    64'h1);
        frame_end();
        check("cancel_cfg_out",       64'(cfg_out),   64'hABCDE12345678);
        check("cancel_start_count",   64'(start_cnt - starts_before), 64'h1);
        check("cancel_start_latency", 64'(start_cyc - commit_cyc),    64'h1);

        // Reset mid-frame with sen held high
        starts_before = start_cnt;
        frame_begin();
        send_bits(64'h0FEDCBA987654, 20);
        check("mid_busy_pre_reset", 64'(busy), 64'h1);
        reset = 1'b1;
        wait_clks(1);
        reset = 1'b0;
        check("mid_rst_cfg_out",     64'(cfg_out),     64'h0);
        check("mid_rst_cfg_valid",   64'(cfg_valid),   64'h0);
        check("mid_rst_start",       64'(start),       64'h0);
        check("mid_rst_frame_error", 64'(frame_error), 64'h0);
        check("mid_rst_busy",        64'(busy),        64'h0);
        send_bits(64'h0FEDCBA987654 >> 20, 32);
        frame_end();
        check("mid_frame_error", 64'(frame_error), 64'h1);
        check("mid_cfg_valid",   64'(cfg_valid),   64'h0);
        check("mid_cfg_out",     64'(cfg_out),     64'h0);
        check("mid_no_start",    64'(start_cnt - starts_before), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
